kros: RTL and testbench

- Board-level LED pattern sequencer for a 10-LED / six-digit 7-segment board.
- Generates one of eight LED animation sequences on LEDR, stepped by a programmable slow tick derived from CLK_50.
- Four active-low pushbuttons select the sequence (wrapping) and the step rate (saturating).
- Current sequence number and rate level are shown on the HEX displays.

---
 rtl/kros.sv | 190 +++++++++++++++++++
 tb/tb_kros.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/kros.sv
// LED pattern sequencer: debounced buttons pick one of eight LEDR animations and
// the step rate; the current sequence and rate level are shown on the HEX digits.
module kros #(
    parameter int unsigned BASE_DIV   = 64,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       pb_freq_up,
    input  logic       pb_freq_dn,
    input  logic       pb_seq_up,
    input  logic       pb_seq_dn,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int unsigned NB   = 4;
    localparam int unsigned FULL = BASE_DIV * 16;
    localparam int unsigned TW   = (FULL > 1) ? $clog2(FULL) : 1;
    localparam int unsigned CW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned SW   = 10;

    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [NB-1:0]         pb_raw;
    logic [NB-1:0]         sync1_q, sync2_q;
    logic [NB-1:0]         armed_q, armed_d;
    logic [NB-1:0]         pulse_q, pulse_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;

    logic [2:0]    seq_q, seq_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] tick_max;
    logic [31:0]   period;
    logic          fu, fd, su, sd;

    logic [9:0] led_q, led_d;
    logic [6:0] hex0_q, hex3_q, hex0_d, hex3_d;

    assign pb_raw = {pb_seq_dn, pb_seq_up, pb_freq_dn, pb_freq_up};
    assign fu = pulse_q[0];
    assign fd = pulse_q[1];
    assign su = pulse_q[2];
    assign sd = pulse_q[3];

    function automatic logic [6:0] digit(input logic [2:0] d);
        case (d)
            3'd0:    return 7'h40;
            3'd1:    return 7'h79;
            3'd2:    return 7'h24;
            3'd3:    return 7'h30;
            3'd4:    return 7'h19;
            3'd5:    return 7'h12;
            3'd6:    return 7'h02;
            default: return 7'h78;
        endcase
    endfunction

    function automatic logic [SW-1:0] last_step(input logic [2:0] seq);
        case (seq)
            3'd0:    return SW'(9);
            3'd1:    return SW'(9);
            3'd2:    return SW'(17);
            3'd3:    return SW'(1023);
            3'd4:    return SW'(10);
            3'd5:    return SW'(1);
            3'd6:    return SW'(4);
            default: return SW'(1);
        endcase
    endfunction

    function automatic logic [9:0] pattern(input logic [2:0] seq, input logic [SW-1:0] s);
        logic [3:0] p;
        logic [3:0] pos;
        p   = s[3:0];
        pos = (s <= SW'(9)) ? p : 4'(SW'(18) - s);
        case (seq)
            3'd0:    return 10'd1 << p;
            3'd1:    return 10'd1 << (4'd9 - p);
            3'd2:    return 10'd1 << pos;
            3'd3:    return s;
            3'd4:    return 10'((11'd1 << p) - 11'd1);
            3'd5:    return s[0] ? 10'h2AA : 10'h155;
            3'd6:    return (10'd1 << p) | (10'd1 << (4'd9 - p));
            default: return s[0] ? 10'h000 : 10'h3FF;
        endcase
    endfunction

    // Debounce: count consecutive low samples while armed; one pulse, then wait for high.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        pulse_d = '0;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i]) begin
                cnt_d[i]   = '0;
                armed_d[i] = 1'b1;
            end else if (armed_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    pulse_d[i] = 1'b1;
                    armed_d[i] = 1'b0;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        seq_d    = seq_q;
        lvl_d    = lvl_q;
        step_d   = step_q;
        tick_d   = tick_q;
        period   = FULL >> lvl_q;
        tick_max = TW'(period - 32'd1);

        if (su ^ sd) begin
            seq_d  = su ? seq_q + 3'd1 : seq_q - 3'd1;
            step_d = '0;
            tick_d = '0;
        end else if (tick_q == tick_max) begin
            tick_d = '0;
            step_d = (step_q == last_step(seq_q)) ? '0 : step_q + SW'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end

        // A saturated no-op leaves the tick phase alone.
        if (fu && !fd && lvl_q != 3'd7) begin
            lvl_d  = lvl_q + 3'd1;
            tick_d = '0;
        end else if (fd && !fu && lvl_q != 3'd0) begin
            lvl_d  = lvl_q - 3'd1;
            tick_d = '0;
        end

        led_d  = pattern(seq_q, step_q);
        hex0_d = digit(seq_q);
        hex3_d = digit(lvl_q);
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            armed_q <= '1;
            pulse_q <= '0;
            cnt_q   <= '0;
            seq_q   <= 3'd0;
            lvl_q   <= 3'd4;
            step_q  <= '0;
            tick_q  <= '0;
            led_q   <= 10'h001;
            hex0_q  <= 7'h40;
            hex3_q  <= 7'h19;
        end else begin
            sync1_q <= pb_raw;
            sync2_q <= sync1_q;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            lvl_q   <= lvl_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            hex0_q  <= hex0_d;
            hex3_q  <= hex3_d;
        end
    end

    assign LEDR = led_q;
    assign HEX0 = hex0_q;
    assign HEX1 = SEG_S;
    assign HEX2 = SEG_BLANK;
    assign HEX3 = hex3_q;
    assign HEX4 = SEG_F;
    assign HEX5 = SEG_BLANK;

endmodule

// File: tb/tb_kros.sv
// Directed bench for kros: walk timing, sequence/rate buttons, debounce, async reset.
module tb_kros;

    logic       CLK_50 = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] pb     = 4'hF;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int passed = 0;
    int total  = 0;

    kros #(.BASE_DIV(64), .DEB_CYCLES(16)) dut (
        .CLK_50    (CLK_50),
        .reset     (reset),
        .pb_freq_up(pb[0]),
        .pb_freq_dn(pb[1]),
        .pb_seq_up (pb[2]),
        .pb_seq_dn (pb[3]),
        .LEDR      (LEDR),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    always #10 CLK_50 = ~CLK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ledr"}, 32'(LEDR), 32'h001);
        check({tag, "_hex0"}, 32'(HEX0), 32'h40);
        check({tag, "_hex1"}, 32'(HEX1), 32'h12);
        check({tag, "_hex2"}, 32'(HEX2), 32'h7F);
        check({tag, "_hex3"}, 32'(HEX3), 32'h19);
        check({tag, "_hex4"}, 32'(HEX4), 32'h0E);
        check({tag, "_hex5"}, 32'(HEX5), 32'h7F);
    endtask

    // Waits (bounded) for LEDR to change; returns cycles elapsed and the new value.
    task automatic wait_chg(output int n, output logic [9:0] v);
        logic [9:0] start;
        start = LEDR;
        n = 0;
        while (n < 3000) begin
            @(negedge CLK_50);
            n++;
            if (LEDR !== start) break;
        end
        if (LEDR === start) check("led_timeout", 32'(n), 32'd0);
        v = LEDR;
    endtask

    // mask bit set = button held low for nlow cycles, then 10 idle cycles.
    task automatic press(input logic [3:0] mask, input int nlow);
        @(negedge CLK_50);
        pb = ~mask;
        repeat (nlow) @(negedge CLK_50);
        pb = 4'hF;
        repeat (10) @(negedge CLK_50);
    endtask

    task automatic pulse_reset();
        @(negedge CLK_50);
        reset = 1'b1;
        @(negedge CLK_50);
        reset = 1'b0;
    endtask

    initial begin
        int         n;
        logic [9:0] v;
        int         pos;

        #25;
        check_reset("rst");
        @(negedge CLK_50);
        reset = 1'b0;

        // walk left: 0x002 first, then 64-cycle steps wrapping to 0x001
        wait_chg(n, v);
        check("walk1", 32'(v), 32'h002);
        for (int i = 2; i <= 10; i++) begin
            wait_chg(n, v);
            check("walk_val", 32'(v), 32'(10'd1 << (i % 10)));
            check("walk_per", 32'(n), 32'd64);
        end

        // seq 1: walk right
        press(4'b0100, 50);
        check("seq1_hex0", 32'(HEX0), 32'h79);
        check("seq1_led0", 32'(LEDR), 32'h200);
        wait_chg(n, v);
        check("seq1_led1", 32'(v), 32'h100);
        wait_chg(n, v);
        check("seq1_led2", 32'(v), 32'h080);
        check("seq1_per", 32'(n), 32'd64);

        // seq 2: bounce
        press(4'b0100, 50);
        check("seq2_hex0", 32'(HEX0), 32'h24);
        check("seq2_led0", 32'(LEDR), 32'h001);
        for (int i = 1; i <= 10; i++) begin
            wait_chg(n, v);
            pos = (i <= 9) ? i : 18 - i;
            check("bounce_val", 32'(v), 32'(10'd1 << pos));
            if (i >= 2) check("bounce_per", 32'(n), 32'd64);
        end

        // seq_dn from 0 wraps to 7: blink
        pulse_reset();
        press(4'b1000, 50);
        check("seq7_hex0", 32'(HEX0), 32'h78);
        check("seq7_led0", 32'(LEDR), 32'h3FF);
        wait_chg(n, v);
        check("seq7_led1", 32'(v), 32'h000);
        wait_chg(n, v);
        check("seq7_led2", 32'(v), 32'h3FF);
        check("seq7_per", 32'(n), 32'd64);

        // rate: up to saturation, then down to level 0
        pulse_reset();
        repeat (4) press(4'b0001, 50);
        check("lvl7_hex3", 32'(HEX3), 32'h78);
        wait_chg(n, v);
        wait_chg(n, v);
        check("lvl7_per", 32'(n), 32'd8);
        press(4'b0001, 50);
        check("lvl7_sat_hex3", 32'(HEX3), 32'h78);
        wait_chg(n, v);
        wait_chg(n, v);
        check("lvl7_sat_per", 32'(n), 32'd8);
        repeat (7) press(4'b0010, 50);
        check("lvl0_hex3", 32'(HEX3), 32'h40);
        wait_chg(n, v);
        wait_chg(n, v);
        check("lvl0_per", 32'(n), 32'd1024);

        // glitch and simultaneous presses are ignored
        press(4'b0100, 5);
        check("glitch_hex0", 32'(HEX0), 32'h40);
        press(4'b1100, 50);
        check("both_seq_hex0", 32'(HEX0), 32'h40);
        press(4'b0011, 50);
        check("both_freq_hex3", 32'(HEX3), 32'h40);

        // asynchronous reset mid-operation
        press(4'b0100, 50);
        check("pre_areset_hex0", 32'(HEX0), 32'h79);
        repeat (7) @(negedge CLK_50);
        #3;
        reset = 1'b1;
        #1;
        check_reset("areset");
        @(negedge CLK_50);
        reset = 1'b0;
        repeat (4) @(negedge CLK_50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
